// File: rtl/fir_tdm_scheduler.sv
// Time-division scheduler that shares one channel-interleaved FIR filter
// among NUM_CH sample streams. One sample per channel is collected into a
// holding register. The complete frame is then issued to the filter in
// channel order 0..NUM_CH-1 on consecutive cycles. Filter results are tagged
// with their channel number on the way back out.
module fir_tdm_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 26,
  parameter int CH_WIDTH     = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_CH-1:0]             s_valid,
  input  logic [NUM_CH*INPUT_WIDTH-1:0] s_data,
  output logic [NUM_CH-1:0]             s_ready,
  output logic                          filt_valid_in,
  output logic [INPUT_WIDTH-1:0]        filt_din,
  input  logic                          filt_valid_out,
  input  logic [OUTPUT_WIDTH-1:0]       filt_dout,
  output logic                          m_valid,
  output logic [CH_WIDTH-1:0]           m_chan,
  output logic [OUTPUT_WIDTH-1:0]       m_data,
  output logic [15:0]                   frame_cnt
);

  typedef enum logic {COLLECT, ISSUE} state_t;

  localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(NUM_CH - 1);
  localparam logic [CH_WIDTH-1:0] CH_ONE  = CH_WIDTH'(1);

  state_t                 state, state_next;
  logic [NUM_CH-1:0]      full;
  logic [INPUT_WIDTH-1:0] hold [NUM_CH];
  logic [NUM_CH-1:0]      accept;
  logic [CH_WIDTH-1:0]    issue_cnt;
  logic [CH_WIDTH-1:0]    out_cnt;
  logic                   issuing;
  logic                   issue_last;

  // A channel can accept a sample whenever its holding register is empty.
  // The ready signal is forced low while reset is held.
  assign s_ready    = rst ? '0 : ~full;
  assign accept     = s_valid & ~full;
  assign issuing    = (state == ISSUE);
  assign issue_last = issuing && (issue_cnt == LAST_CH);

  // State register.
  // NOTE: sequential state uses non-blocking assignments (<=). This ensures
  // every flop samples values from before the clock edge, so the result does
  // not depend on the order in which the always blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  // Next-state logic. The FSM leaves COLLECT only when a full frame is held
  // and issue is enabled. Once a frame has started, it always completes.
  // NOTE: state_next gets a default value before the case statement. Every
  // path therefore assigns it, and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (&full && enable) state_next = ISSUE;
      ISSUE:   if (issue_cnt == LAST_CH) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Full flags. Issuing a channel empties it. An empty channel fills on a
  // handshake. A flag can never be set and cleared on the same edge, because
  // the accept requires the flag to already be clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (issuing && issue_cnt == CH_WIDTH'(c)) full[c] <= 1'b0;
        else if (accept[c])                       full[c] <= 1'b1;
      end
    end
  end

  // Holding registers capture the sample on each accepted handshake.
  // NOTE: the holding registers have no reset. Their contents are only
  // meaningful while the matching full flag is set, and reset clears every
  // flag. Leaving the reset off keeps this storage as plain data flops.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (accept[c]) hold[c] <= s_data[c*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

  // Issue datapath. In ISSUE, one held sample goes to the filter per cycle.
  // After the last channel, the frame counter advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt     <= '0;
      filt_valid_in <= 1'b0;
      filt_din      <= '0;
      frame_cnt     <= '0;
    end else if (issuing) begin
      filt_valid_in <= 1'b1;
      filt_din      <= hold[issue_cnt];
      if (issue_last) begin
        issue_cnt <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        issue_cnt <= issue_cnt + CH_ONE;
      end
    end else begin
      filt_valid_in <= 1'b0;
      issue_cnt     <= '0;
    end
  end

  // Output demux. Results leave the filter in channel order, so a wrapping
  // counter recovers the channel tag. The result is registered, which gives
  // one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
      m_valid <= 1'b0;
      m_chan  <= '0;
      m_data  <= '0;
    end else if (filt_valid_out) begin
      m_valid <= 1'b1;
      m_chan  <= out_cnt;
      m_data  <= filt_dout;
      out_cnt <= (out_cnt == LAST_CH) ? '0 : out_cnt + CH_ONE;
    end else begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fir_tdm_scheduler.md
Name: fir_tdm_scheduler

Overview:
- Time-division scheduler that shares one channel-interleaved FIR filter instance among NUM_CH independent sample streams.
- Collects one sample per channel into holding registers, then issues the frame to the filter in strict channel order 0..NUM_CH-1 on consecutive cycles.
- Tags filter results with their channel number on the way out.
- Sits between the per-channel front-end sources and the filter's valid_in/din/valid_out/dout ports.

Parameters:
- NUM_CH, 4, number of channels sharing the filter (>=2).
- INPUT_WIDTH, 16, sample width per channel; equals filter INPUT_WIDTH.
- OUTPUT_WIDTH, 26, filter result width; equals filter OUTPUT_WIDTH.
- CH_WIDTH, $clog2(NUM_CH), channel index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  1 = issue frames; 0 = stop after the frame in progress.
- s_valid  in  NUM_CH  per-channel sample valid.
- s_data  in  NUM_CH*INPUT_WIDTH  per-channel samples; channel c occupies bits [c*INPUT_WIDTH +: INPUT_WIDTH].
- s_ready  out  NUM_CH  per-channel ready.
- filt_valid_in  out  1  to filter valid_in.
- filt_din  out  INPUT_WIDTH  to filter din.
- filt_valid_out  in  1  from filter valid_out.
- filt_dout  in  OUTPUT_WIDTH  from filter dout.
- m_valid  out  1  tagged result valid; single-cycle pulse, no backpressure.
- m_chan  out  CH_WIDTH  channel of m_data.
- m_data  out  OUTPUT_WIDTH  filter result.
- frame_cnt  out  16  frames issued, wraps at 65535->0.

Behaviour:
- Reset (async assert, sync release):
  - state=COLLECT; all full flags, issue_cnt, out_cnt, frame_cnt = 0.
  - filt_valid_in=0, filt_din=0, m_valid=0, m_chan=0, m_data=0.
  - s_ready=0 while rst is high.
- Input handshake:
  - s_ready[c] = ~full[c] (combinational from the register).
  - Accept when s_valid[c] & s_ready[c] at a clock edge: hold[c] <= sample, full[c] <= 1.
  - Channels fill independently and in any order.
  - A full channel holds its sample; no overwrite, no drop.
- FSM COLLECT:
  - If all full flags = 1 and enable = 1, go to ISSUE next edge with issue_cnt = 0.
  - Otherwise stay in COLLECT.
- FSM ISSUE, each edge:
  - filt_valid_in <= 1, filt_din <= hold[issue_cnt], full[issue_cnt] <= 0, issue_cnt++.
  - On the edge where issue_cnt = NUM_CH-1: issue_cnt <= 0, frame_cnt++, state <= COLLECT.
  - enable is ignored while in ISSUE; a started frame always completes.
- filt_valid_in is registered. It is high for exactly NUM_CH consecutive cycles per frame and low in every other cycle.
- Timing: last filling accept at edge E0 -> ISSUE at E1 -> channel 0 presented after E2 … channel NUM_CH-1 after E(NUM_CH+1).
  - Minimum spacing between frame starts is NUM_CH+2 cycles.
- Refill during ISSUE:
  - A channel cleared earlier in the frame may accept its next sample immediately; that sample belongs to the next frame.
  - issue_cnt only moves forward, so a sample is never issued twice.
- Output demux:
  - On filt_valid_out: m_valid <= 1, m_data <= filt_dout, m_chan <= out_cnt.
  - out_cnt wraps NUM_CH-1 -> 0.
  - Latency filt_valid_out -> m_valid is 1 cycle, independent of filter pipeline depth.
  - out_cnt is cleared only by rst; filter ordering guarantees channel alignment.
- enable=0 in COLLECT: samples are still accepted into holding registers; nothing is issued until enable=1.
- Reset mid-frame: issue is aborted, holding data is discarded, and filt_valid_in drops asynchronously. The filter must be reset with the same rst to keep out_cnt aligned.

Test Plan:
- NUM_CH=4, enable=1; channels 0..3 present 0x0010, 0x0020, 0x0030, 0x0040 in the same cycle -> filt_valid_in high 4 consecutive cycles with din 0x0010, 0x0020, 0x0030, 0x0040; frame_cnt=1.
- Channel 2 presents its sample 5 cycles after the others -> no filt_valid_in before the channel-2 accept; issue starts 2 edges after it; s_ready[0,1,3]=0 while waiting.
- Channel 0 s_valid held high continuously with incrementing data -> channel 0 re-accepted right after its issue; next frame carries the new value; no sample duplicated or lost over 100 frames (scoreboard).
- Drive filt_valid_out with 8 pulses, data 1..8, including gaps -> m_valid pulses 1 cycle later with m_chan 0,1,2,3,0,1,2,3 and m_data 1..8.
- enable=0 with all channels full -> no issue and s_ready=0; raise enable -> issue starts 1 edge later.
- Assert rst during the 3rd issue cycle -> filt_valid_in, m_valid and s_ready go 0 immediately and frame_cnt=0; after release, a fresh frame issues in order from channel 0.
